// File: rtl/conv_encoder_pkg.sv
// Shared code definition for the (7,5) K=3 convolutional encoder/decoder pair.
// Tail flushing is enabled by defining CONV_ENC_TAIL_FLUSH_EN.
package conv_pkg;
  localparam int R_DEF = 2;
  localparam int K_DEF = 3;
  localparam logic [2:0] POLY0_DEF = 3'b111;
  localparam logic [2:0] POLY1_DEF = 3'b101;

`ifdef CONV_ENC_TAIL_FLUSH_EN
  localparam bit TAIL_FLUSH = 1'b1;
`else
  localparam bit TAIL_FLUSH = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, DONE = 2'd2} state_e;

  // With a tail, K-1 zero bits follow the message to return the encoder to state 0.
  function automatic int n_sym_f(input int len_msg, input int k, input bit tail);
    return tail ? len_msg + k - 1 : len_msg;
  endfunction

  function automatic int code_w_f(input int r, input int len_msg, input int k, input bit tail);
    return r * n_sym_f(len_msg, k, tail);
  endfunction
endpackage

// File: rtl/conv_encoder_core.sv
// Convolutional shift register and parity taps; advances one input bit per enabled cycle.
module conv_enc_core
  import conv_pkg::*;
#(
  parameter int         K     = K_DEF,
  parameter logic [K-1:0] POLY0 = POLY0_DEF,
  parameter logic [K-1:0] POLY1 = POLY1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       adv_i,
  input  logic       bit_i,
  output logic [1:0] sym_o
);

  logic [K-2:0] sr_q, sr_d;
  logic [K-1:0] win;

  // Newest bit enters at the MSB; sr_q[0] is the oldest.
  assign sr_d = {bit_i, sr_q[K-2:1]};
  assign win  = {bit_i, sr_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       sr_q <= '0;
    else if (clr_i) sr_q <= '0;
    else if (adv_i) sr_q <= sr_d;
  end

  assign sym_o = {^(win & POLY0), ^(win & POLY1)};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder: streams symbols over a valid/ready handshake
// and assembles the packed codeword (symbol 0 in the MSBs). Optional CONV_ENC_TAIL_FLUSH_EN.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int           R       = R_DEF,
  parameter int           K       = K_DEF,
  parameter int           LEN_MSG = 5,
  parameter logic [K-1:0] POLY0   = POLY0_DEF,
  parameter logic [K-1:0] POLY1   = POLY1_DEF,
  localparam int          N_SYM   = n_sym_f(LEN_MSG, K, TAIL_FLUSH),
  localparam int          CODE_W  = code_w_f(R, LEN_MSG, K, TAIL_FLUSH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_MSG-1:0]  msg,
  output logic                busy,
  output logic                code_valid,
  output logic [R-1:0]        code_sym,
  input  logic                sym_ready,
  output logic [CODE_W-1:0]   codeword,
  output logic                done
);

  localparam int CNT_W = $clog2(N_SYM + 1);

  state_e               state_q, state_d;
  logic [LEN_MSG-1:0]   msg_q, msg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0]    acc_q, acc_d;
  logic [CODE_W-1:0]    cw_q, cw_d;
  logic                 clr, adv, bit_in, last;
  logic [R-1:0]         sym;

  // Past the message the window is fed zeros (tail bits).
  assign bit_in = (cnt_q < CNT_W'(LEN_MSG)) ? msg_q[cnt_q] : 1'b0;
  assign last   = (cnt_q == CNT_W'(N_SYM - 1));
  assign adv    = (state_q == ENC) && sym_ready;

  conv_enc_core #(
    .K     (K),
    .POLY0 (POLY0),
    .POLY1 (POLY1)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .adv_i (adv),
    .bit_i (bit_in),
    .sym_o (sym)
  );

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    cw_d    = cw_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          msg_d   = msg;
          cnt_d   = '0;
          acc_d   = '0;
          clr     = 1'b1;
          state_d = ENC;
        end
      end
      ENC: begin
        if (sym_ready) begin
          acc_d = {acc_q[CODE_W-R-1:0], sym};
          cnt_d = cnt_q + CNT_W'(1);
          // Load the whole frame at once so it is visible during the DONE cycle.
          if (last) begin
            cw_d    = {acc_q[CODE_W-R-1:0], sym};
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      msg_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      cw_q    <= cw_d;
    end
  end

  assign busy       = (state_q == ENC);
  assign code_valid = (state_q == ENC);
  assign code_sym   = code_valid ? sym : '0;
  assign done       = (state_q == DONE);
  assign codeword   = cw_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder with a convolution-sum reference model.
module tb_conv_encoder;
  localparam int LEN = 5;
  localparam int K   = 3;
`ifdef CONV_ENC_TAIL_FLUSH_EN
  localparam int N = LEN + K - 1;
`else
  localparam int N = LEN;
`endif
  localparam int CW = 2 * N;
  localparam logic [K-1:0] P0 = 3'b111;
  localparam logic [K-1:0] P1 = 3'b101;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [LEN-1:0] msg;
  logic           busy, code_valid, sym_ready, done;
  logic [1:0]     code_sym;
  logic [CW-1:0]  codeword;

  int total = 0;
  int bad   = 0;

  logic [1:0]     sym_q [$];
  logic [CW-1:0]  cw_q  [$];
  logic [LEN-1:0] msg_q [$];

  always #5 clk = ~clk;

  conv_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .msg        (msg),
    .busy       (busy),
    .code_valid (code_valid),
    .code_sym   (code_sym),
    .sym_ready  (sym_ready),
    .codeword   (codeword),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Symbol i is the GF(2) convolution of the input sequence u (zero before time 0
  // and past the message) with each generator, tap K-1 applied to u[i].
  function automatic logic [1:0] sym_at(input logic [LEN-1:0] m, input int i);
    logic [1:0] s = 2'b00;
    logic ub;
    for (int t = 0; t < K; t++) begin
      ub = ((i - t) >= 0 && (i - t) < LEN) ? m[i-t] : 1'b0;
      s[1] ^= P0[K-1-t] & ub;
      s[0] ^= P1[K-1-t] & ub;
    end
    return s;
  endfunction

  function automatic logic [CW-1:0] calc_cw(input logic [LEN-1:0] m);
    logic [CW-1:0] c = '0;
    for (int i = 0; i < N; i++) c = {c[CW-3:0], sym_at(m, i)};
    return c;
  endfunction

  // Maximum-likelihood decode by exhaustive search (stands in for the Viterbi decoder).
  function automatic logic [LEN-1:0] ml_decode(input logic [CW-1:0] c);
    logic [LEN-1:0] best = '0;
    int bestd = CW + 1;
    int d;
    for (int cand = 0; cand < (1 << LEN); cand++) begin
      d = $countones(calc_cw(LEN'(cand)) ^ c);
      if (d < bestd) begin
        bestd = d;
        best  = LEN'(cand);
      end
    end
    return best;
  endfunction

  task automatic push_expect(input logic [LEN-1:0] m);
    for (int i = 0; i < N; i++) sym_q.push_back(sym_at(m, i));
    cw_q.push_back(calc_cw(m));
    msg_q.push_back(m);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("busy_vs_valid", 32'(busy), 32'(code_valid));
      if (code_valid) begin
        if (sym_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sym_unexpected actual=%b required=none", code_sym);
        end else begin
          chk("code_sym", 32'(code_sym), 32'(sym_q[0]));
          if (sym_ready) void'(sym_q.pop_front());
        end
      end
      if (done) begin
        if (cw_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected actual=1 required=0 cw=%0h", codeword);
        end else begin
          chk("codeword", 32'(codeword), 32'(cw_q[0]));
          chk("loopback", 32'(ml_decode(codeword)), 32'(msg_q[0]));
          chk("done_not_busy", 32'(busy), 32'd0);
          void'(cw_q.pop_front());
          void'(msg_q.pop_front());
        end
      end
    end
  end

  // mode 0: ready high; 1: 3-cycle stall on symbol 1; 2: random ready; 3: stray start mid-frame.
  task automatic run_frame(input logic [LEN-1:0] m, input int mode, input int exp_lat);
    int cyc;
    bit got;
    msg = m;
    start = 1'b1;
    sym_ready = 1'b1;
    push_expect(m);
    @(posedge clk); #1;
    start = 1'b0;
    msg = LEN'($urandom);
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 200) begin
      if (mode == 1) sym_ready = !(cyc >= 2 && cyc <= 4);
      else if (mode == 2) sym_ready = ($urandom_range(0, 3) != 0);
      if (mode == 3) begin
        start = (cyc == 2);
        msg = ~m;
      end
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    if (exp_lat > 0) chk("latency", 32'(cyc), 32'(exp_lat));
    start = 1'b0;
    sym_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b0;
    start = 1'b0;
    msg = '0;
    sym_ready = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_sym", 32'(code_sym), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_codeword", 32'(codeword), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_frame(5'b01101, 0, N + 1);
`ifdef CONV_ENC_TAIL_FLUSH_EN
    chk("cw_01101", 32'(codeword), 32'h385C);
`else
    chk("cw_01101", 32'(codeword), 32'h385);
`endif
    run_frame(5'b11111, 0, N + 1);
`ifdef CONV_ENC_TAIL_FLUSH_EN
    chk("cw_11111", 32'(codeword), 32'h36A7);
`else
    chk("cw_11111", 32'(codeword), 32'h36A);
`endif
    run_frame(5'b00000, 0, N + 1);
    chk("cw_zero", 32'(codeword), 32'd0);
    run_frame(5'b01101, 1, N + 4);
    run_frame(5'b01101, 3, N + 1);

    // Back-to-back with start held high.
    start = 1'b1;
    msg = 5'b01101;
    push_expect(5'b01101);
    @(posedge clk); #1;
    msg = 5'b10010;
    push_expect(5'b10010);
    cnt = 0;
    while (!done && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("b2b_first_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("b2b_idle_gap", 32'(code_valid), 32'd0);
    @(posedge clk); #1;
    chk("b2b_restart", 32'(code_valid), 32'd1);
    start = 1'b0;
    msg = '0;
    cnt = 0;
    while (!done && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("b2b_second_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset mid-frame.
    msg = 5'b01101;
    start = 1'b1;
    push_expect(5'b01101);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(code_valid), 32'd0);
    chk("arst_sym", 32'(code_sym), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_codeword", 32'(codeword), 32'd0);
    sym_q.delete();
    cw_q.delete();
    msg_q.delete();
    @(posedge clk); #1;
    chk("arst_hold_cw", 32'(codeword), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_frame(5'b01101, 0, N + 1);

    for (int f = 0; f < 20; f++) run_frame(LEN'($urandom), 2, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sym_q.size() + cw_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
